// File: rtl/lea_serial_arx.sv
// lea_serial_arx: bit-serial add-rotate-xor word step for a LEA-style round.
// Computes Z = ROL((X^RK_A) + (Y^RK_B), ROT) one bit per clock, LSB first,
// with the carry out of bit 31 reported on COUT.
// Optional feature macro: LEA_ROT_EN (defined -> rotate the sum left by ROT;
// undefined -> Z is the plain sum and ROT has no effect).
module lea_serial_arx #(
  parameter int ROT = 9
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [31:0] X,
  input  logic [31:0] Y,
  input  logic [31:0] RK_A,
  input  logic [31:0] RK_B,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] Z,
  output logic        COUT
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

`ifdef LEA_ROT_EN
  localparam int ROT_EFF = ROT % 32;
`else
  // Rotation disabled in this build: the amount collapses to zero.
  localparam int ROT_EFF = ROT * 0;
`endif

  logic [1:0]  state;
  logic [31:0] a_sr;
  logic [31:0] b_sr;
  logic [31:0] res_sr;
  logic        carry;
  logic [4:0]  cnt;

  logic        sum_bit;
  logic        carry_next;
  logic [31:0] sum_word;
  logic [31:0] z_next;

  // One full-adder slice plus the final (optionally rotated) result word.
  always_comb begin
    sum_bit    = a_sr[0] ^ b_sr[0] ^ carry;
    carry_next = (a_sr[0] & b_sr[0]) | ((a_sr[0] ^ b_sr[0]) & carry);
    // Sum word as it will look once this cycle's bit is shifted in at bit 31.
    sum_word   = {sum_bit, res_sr[31:1]};
    // With ROT_EFF = 0 the right shift is by 32 and contributes nothing.
    z_next     = (sum_word << ROT_EFF) | (sum_word >> (32 - ROT_EFF));
  end

  // Control FSM and serial datapath; reset clears everything immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      Z      <= '0;
      COUT   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            a_sr  <= X ^ RK_A;
            b_sr  <= Y ^ RK_B;
            carry <= 1'b0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= sum_word;
          carry  <= carry_next;
          // Counter wraps 31 -> 0 on the last bit, ready for the next word.
          cnt    <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            Z     <= z_next;
            COUT  <= carry_next;
            state <= FIN;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign BUSY = (state != IDLE);
  assign DONE = (state == FIN);

endmodule

// File: tb/tb_lea_serial_arx.sv
// Directed self-checking bench for lea_serial_arx (default ROT = 9).
// Expected results are hand-computed for both LEA_ROT_EN settings.
module tb_lea_serial_arx;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [31:0] X, Y, RK_A, RK_B;
  logic        BUSY, DONE, COUT;
  logic [31:0] Z;

  int total = 0;
  int bad   = 0;

`ifdef LEA_ROT_EN
  localparam bit ROT_ON = 1'b1;
`else
  localparam bit ROT_ON = 1'b0;
`endif

  lea_serial_arx #(.ROT(9)) dut (
    .CLK(CLK), .RST(RST), .START(START),
    .X(X), .Y(Y), .RK_A(RK_A), .RK_B(RK_B),
    .BUSY(BUSY), .DONE(DONE), .Z(Z), .COUT(COUT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] pick(input logic [31:0] zrot, input logic [31:0] zplain);
    return ROT_ON ? zrot : zplain;
  endfunction

  // Present one operand set for exactly one sampling edge, then scramble inputs.
  task automatic issue(input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] ka, input logic [31:0] kb);
    @(posedge CLK); #1;
    START = 1'b1; X = x; Y = y; RK_A = ka; RK_B = kb;
    @(posedge CLK); #1;
    START = 1'b0;
    X = $urandom; Y = $urandom; RK_A = $urandom; RK_B = $urandom;
  endtask

  // Count edges after the START edge until DONE (bounded).
  task automatic wait_done(output int edges);
    edges = 0;
    while (edges < 40 && DONE !== 1'b1) begin
      @(posedge CLK); #1;
      edges++;
    end
  endtask

  // Check latency, result, one-cycle DONE and return to IDLE.
  task automatic check_op(input string name, input int edges,
                          input logic [31:0] expz, input logic expc);
    total++;
    if (edges !== 32) begin
      bad++; $display("FAIL %s latency: got %0d edges, want 32", name, edges);
    end
    total++;
    if (Z !== expz || COUT !== expc) begin
      bad++; $display("FAIL %s result: Z=%h COUT=%b, want Z=%h COUT=%b", name, Z, COUT, expz, expc);
    end
    total++;
    if (BUSY !== 1'b1) begin
      bad++; $display("FAIL %s busy_in_fin: got %b want 1", name, BUSY);
    end
    @(posedge CLK); #1;
    total++;
    if (DONE !== 1'b0 || BUSY !== 1'b0 || Z !== expz) begin
      bad++; $display("FAIL %s after_done: DONE=%b BUSY=%b Z=%h, want 0 0 %h", name, DONE, BUSY, Z, expz);
    end
    $display("op %s: Z=%h COUT=%b latency=%0d", name, Z, COUT, edges);
  endtask

  task automatic run_vec(input string name, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] ka, input logic [31:0] kb,
                         input logic [31:0] expz, input logic expc);
    int edges;
    issue(x, y, ka, kb);
    total++;
    if (BUSY !== 1'b1 || DONE !== 1'b0) begin
      bad++; $display("FAIL %s start: BUSY=%b DONE=%b, want 1 0", name, BUSY, DONE);
    end
    wait_done(edges);
    check_op(name, edges, expz, expc);
  endtask

  task automatic test_reset();
    RST = 1'b1; START = 1'b0; X = '0; Y = '0; RK_A = '0; RK_B = '0;
    #2;
    total++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || Z !== 32'h0 || COUT !== 1'b0) begin
      bad++; $display("FAIL reset: BUSY=%b DONE=%b Z=%h COUT=%b, want 0 0 0 0", BUSY, DONE, Z, COUT);
    end
    $display("reset: BUSY=%b DONE=%b Z=%h COUT=%b", BUSY, DONE, Z, COUT);
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic test_vectors();
    run_vec("one_plus_two", 32'h00000001, 32'h00000002, 32'h0, 32'h0,
            pick(32'h00000600, 32'h00000003), 1'b0);
    run_vec("carry_wrap", 32'hFFFFFFFF, 32'h00000001, 32'h0, 32'h0,
            32'h00000000, 1'b1);
    run_vec("key_cancel", 32'hFFFFFFFF, 32'h00000005, 32'hFFFFFFFF, 32'h0,
            pick(32'h00000A00, 32'h00000005), 1'b0);
    run_vec("rot_wrap", 32'h80000000, 32'h00000000, 32'h0, 32'h0,
            pick(32'h00000100, 32'h80000000), 1'b0);
    run_vec("all_ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0,
            pick(32'hFFFFFDFF, 32'hFFFFFFFE), 1'b1);
    run_vec("mixed", 32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0,
            pick(32'hE26AD159, 32'hACF13568), 1'b0);
  endtask

  task automatic test_back_to_back();
    int edges;
    int e;
    issue(32'h00000001, 32'h00000002, 32'h0, 32'h0);
    e = 0;
    // Extra START pulses while busy must be ignored.
    while (e < 40 && DONE !== 1'b1) begin
      @(posedge CLK); #1;
      e++;
      if (e == 5 || e == 20) begin
        START = 1'b1; X = 32'h0000FFFF; Y = 32'h12340000;
      end else begin
        START = 1'b0;
      end
    end
    START = 1'b0;
    check_op("ignore_start", e, pick(32'h00000600, 32'h00000003), 1'b0);
    // Now in the first IDLE cycle: START here must launch immediately.
    START = 1'b1; X = 32'hFFFFFFFF; Y = 32'h00000001; RK_A = 32'h0; RK_B = 32'h0;
    @(posedge CLK); #1;
    START = 1'b0; X = $urandom; Y = $urandom;
    total++;
    if (BUSY !== 1'b1) begin
      bad++; $display("FAIL idle_restart: BUSY=%b want 1", BUSY);
    end
    repeat (9) @(posedge CLK);
    #1;
    total++;
    if (Z !== pick(32'h00000600, 32'h00000003)) begin
      bad++; $display("FAIL hold_z: Z=%h want %h", Z, pick(32'h00000600, 32'h00000003));
    end
    wait_done(edges);
    check_op("back_to_back", edges + 9, 32'h00000000, 1'b1);
  endtask

  task automatic test_reset_mid();
    int e;
    int seen;
    issue(32'h00000001, 32'h00000002, 32'h0, 32'h0);
    repeat (15) @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    total++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || Z !== 32'h0 || COUT !== 1'b0) begin
      bad++; $display("FAIL mid_reset: BUSY=%b DONE=%b Z=%h COUT=%b, want 0 0 0 0", BUSY, DONE, Z, COUT);
    end
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;
    seen = 0;
    for (e = 0; e < 40; e++) begin
      @(posedge CLK); #1;
      if (DONE === 1'b1 || BUSY === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++; $display("FAIL no_done_after_reset: active cycles=%0d want 0", seen);
    end
    $display("mid_reset: abandoned operation, active cycles=%0d", seen);
    run_vec("after_reset", 32'h80000000, 32'h00000000, 32'h0, 32'h0,
            pick(32'h00000100, 32'h80000000), 1'b0);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lea_serial_arx.md
LEA_SERIAL_ARX -- requirements
Module: lea_serial_arx

Interface
REQ-001 SHALL have parameter ROT, default 9, meaning left-rotate amount applied to the 32-bit sum (legal 0..31).
REQ-002 SHALL have port CLK  input  1  rising-edge clock.
REQ-003 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port START  input  1  request to begin one ARX word operation.
REQ-005 SHALL have port X  input  32  first state word.
REQ-006 SHALL have port Y  input  32  second state word.
REQ-007 SHALL have port RK_A  input  32  round-key word XORed with X.
REQ-008 SHALL have port RK_B  input  32  round-key word XORed with Y.
REQ-009 SHALL have port BUSY  output  1  high while an operation is in progress.
REQ-010 SHALL have port DONE  output  1  one-cycle pulse marking Z valid.
REQ-011 SHALL have port Z  output  32  result word.
REQ-012 SHALL have port COUT  output  1  carry out of bit 31 of the last addition.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, FIN; only IDLE accepts START.
REQ-014 SHALL, on a clock edge in IDLE with START=1, latch A=X^RK_A and B=Y^RK_B into 32-bit shift registers, clear carry register and 5-bit bit counter, and enter RUN.
REQ-015 SHALL, in RUN, process one bit per cycle, LSB first: sum bit = a0^b0^c; next carry = a0&b0 | (a0^b0)&c; shift A and B right; shift the sum bit into the result register at bit 31.
REQ-016 SHALL leave RUN for FIN after exactly 32 RUN cycles (counter value 31 processed), with wrap of the counter back to 0.
REQ-017 SHALL, on the RUN-to-FIN edge, load Z with the sum (rotated per REQ-026) and COUT with the final carry; the addition is modulo 2^32.
REQ-018 SHALL drive DONE=1 for exactly the one cycle in FIN, then return to IDLE on the next edge.
REQ-019 SHALL meet latency: START sampled at edge n -> DONE high in the cycle after edge n+32, back in IDLE after edge n+33.
REQ-020 SHALL drive BUSY=1 in RUN and FIN, 0 in IDLE.
REQ-021 SHALL ignore START while BUSY=1; no restart, no corruption of the in-flight operation.
REQ-022 SHALL accept START in the same cycle IDLE is re-entered (back-to-back operations every 34 cycles).
REQ-023 SHALL hold Z and COUT stable from DONE until the next RUN-to-FIN edge; X, Y, RK_A, RK_B are don't-care after the START edge.

Reset
REQ-024 SHALL, on RST=1, immediately (asynchronously) force state IDLE, BUSY=0, DONE=0, Z=0x00000000, COUT=0, counter, carry and shift registers to 0.
REQ-025 SHALL, on RST asserted mid-RUN, abandon the operation with no DONE pulse; first START after RST release starts a fresh operation.

Configuration
REQ-026 SHALL use macro LEA_ROT_EN: defined -> Z = ROL(sum, ROT); undefined -> Z = sum, ROT ignored; all other behaviour and timing identical.

Verification
REQ-027 SHALL cover: X=0x00000001, Y=0x00000002, RK_A=RK_B=0, START 1 cycle -> DONE at cycle 33 after START edge, Z=0x00000600 (LEA_ROT_EN, ROT=9) / 0x00000003 (undefined), COUT=0.
REQ-028 SHALL cover: X=0xFFFFFFFF, Y=0x00000001, keys 0 -> Z=0x00000000, COUT=1 (carry discarded from Z).
REQ-029 SHALL cover: X=0xFFFFFFFF, RK_A=0xFFFFFFFF, Y=0x00000005, RK_B=0 -> Z=0x00000A00 (LEA_ROT_EN, ROT=9) / 0x00000005.
REQ-030 SHALL cover: X=0x80000000, Y=0, keys 0 -> Z=0x00000100 with LEA_ROT_EN, ROT=9 (rotation wrap), 0x80000000 without.
REQ-031 SHALL cover: second START pulses at cycles 5 and 20 of RUN -> ignored, single DONE, result of first operand set; START at first IDLE cycle -> immediate new operation.
REQ-032 SHALL cover: RST pulsed at RUN cycle 16 -> outputs zero immediately, no DONE; new operation after release yields correct Z.
